// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port program/data RAM between instruction fetch and
//   the stack path (r8). Grants are combinational and take effect in the same
//   cycle; a READ_LAT-deep tag pipeline steers each read result back to the
//   requester that issued it. A starvation counter forces fetch to win after
//   MAX_WAIT consecutive denied cycles unless the stack holds stack_lock.
//
//   Optional: define RAM_ARB_STATS_EN to add the fetch_stall_cnt debug output.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   fetch_req/addr        fetch read request and address
//   fetch_gnt/rvalid      fetch access issued / rdata holds fetch result
//   stack_req/we/addr     stack request, write enable, address
//   stack_wdata           stack write data
//   stack_lock            keep stack ownership while asserted
//   stack_gnt/rvalid      stack access issued / rdata holds stack result
//   rdata                 shared read data (0 when no rvalid)
//   ram_address/data/wren RAM port drive
//   ram_q                 RAM registered read data
//   fetch_stall_cnt       (RAM_ARB_STATS_EN) denied fetch cycles, wraps
module ram_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   input  logic              stack_req,
   input  logic              stack_we,
   input  logic [ADDR_W-1:0] stack_addr,
   input  logic [DATA_W-1:0] stack_wdata,
   input  logic              stack_lock,
   output logic              stack_gnt,
   output logic              stack_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]       fetch_stall_cnt
`endif
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   logic [3:0]         starve_cnt;
   logic               issue_vld;
   // Tag pipeline, stage 1 loaded from the grant cycle, stage READ_LAT
   // lines up with ram_q.
   logic [READ_LAT:1]  vld_pipe;
   logic [READ_LAT:1]  own_pipe;   // 1 = stack, 0 = fetch

   // Grant selection; nothing is issued while in reset.
   always_comb begin
      fetch_gnt = 1'b0;
      stack_gnt = 1'b0;
      if (!rst) begin
         if (stack_lock && stack_req)
            stack_gnt = 1'b1;
         else if (starve_cnt == MAX_CNT && fetch_req)
            fetch_gnt = 1'b1;
         else if (stack_req)
            stack_gnt = 1'b1;
         else if (fetch_req)
            fetch_gnt = 1'b1;
      end
   end

   // Idle default is the fetch address so the next instruction is always
   // being looked up.
   assign ram_address = stack_gnt ? stack_addr  : fetch_addr;
   assign ram_data    = stack_gnt ? stack_wdata : '0;
   assign ram_wren    = stack_gnt & stack_we;

   // Counts consecutive denied fetch cycles; a held stack_lock can park it
   // at MAX_CNT, which is intended.
   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (!fetch_req || fetch_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != MAX_CNT)
         starve_cnt <= starve_cnt + 4'd1;
   end

   // Writes issue no tag.
   assign issue_vld = fetch_gnt | (stack_gnt & ~stack_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         own_pipe <= '0;
      end else begin
         vld_pipe[1] <= issue_vld;
         own_pipe[1] <= stack_gnt;
         for (int i = 2; i <= READ_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            own_pipe[i] <= own_pipe[i-1];
         end
      end
   end

   // rst gating drops a result landing in the reset cycle itself, so reads
   // in flight at reset are never reported.
   assign fetch_rvalid = vld_pipe[READ_LAT] & ~own_pipe[READ_LAT] & ~rst;
   assign stack_rvalid = vld_pipe[READ_LAT] &  own_pipe[READ_LAT] & ~rst;
   assign rdata        = (fetch_rvalid | stack_rvalid) ? ram_q : '0;

`ifdef RAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         fetch_stall_cnt <= '0;
      else if (fetch_req && !fetch_gnt)
         fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: u_dut (READ_LAT=1) is checked throughout with a
// read-return scoreboard; u_dut2 (READ_LAT=2) shares the stimulus and is
// checked for in-flight discard across reset.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, stack_req, stack_we, stack_lock;
   logic [15:0] fetch_addr, stack_addr, stack_wdata;

   logic        fetch_gnt, fetch_rvalid, stack_gnt, stack_rvalid, ram_wren;
   logic [15:0] rdata, ram_address, ram_data, ram_q;
   logic        fg2, frv2, sg2, srv2, wren2;
   logic [15:0] rdata2, addr2, data2, q2, q2a;
`ifdef RAM_ARB_STATS_EN
   logic [15:0] stall1, stall2;
   int          exp_stall = 0;
`endif

   logic [15:0] mem1    [0:65535];
   logic [15:0] mem2    [0:65535];
   logic [15:0] ref_mem [0:65535];

   typedef struct {
      int          due;
      bit          stk;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;
   int m_cnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .MAX_WAIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
      .stack_req(stack_req), .stack_we(stack_we), .stack_addr(stack_addr),
      .stack_wdata(stack_wdata), .stack_lock(stack_lock),
      .stack_gnt(stack_gnt), .stack_rvalid(stack_rvalid), .rdata(rdata),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q)
`ifdef RAM_ARB_STATS_EN
      , .fetch_stall_cnt(stall1)
`endif
   );

   ram_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(2), .MAX_WAIT(4)) u_dut2 (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fg2), .fetch_rvalid(frv2),
      .stack_req(stack_req), .stack_we(stack_we), .stack_addr(stack_addr),
      .stack_wdata(stack_wdata), .stack_lock(stack_lock),
      .stack_gnt(sg2), .stack_rvalid(srv2), .rdata(rdata2),
      .ram_address(addr2), .ram_data(data2), .ram_wren(wren2),
      .ram_q(q2)
`ifdef RAM_ARB_STATS_EN
      , .fetch_stall_cnt(stall2)
`endif
   );

   // RAM models: registered read, read-before-write.
   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem1[i]    = 16'(i) ^ 16'h5A3C;
         mem2[i]    = 16'(i) ^ 16'h5A3C;
         ref_mem[i] = 16'(i) ^ 16'h5A3C;
      end
   end

   always @(posedge clk) begin
      if (ram_wren) mem1[ram_address] <= ram_data;
      ram_q <= mem1[ram_address];
      if (wren2) mem2[addr2] <= data2;
      q2a <= mem2[addr2];
      q2  <= q2a;
   end

   // Read-return checker for u_dut.
   always @(negedge clk) begin
      logic        efv, esv;
      logic [15:0] ed;
      exp_t        e;
      if (chk_en) begin
         efv = 1'b0; esv = 1'b0; ed = '0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            efv = !e.stk;
            esv = e.stk;
            ed  = e.data;
         end
         checks++;
         if ({fetch_rvalid, stack_rvalid, rdata} !== {efv, esv, ed}) begin
            errors++;
            $display("FAIL rvalid_return cyc=%0d got frv=%b srv=%b rdata=%h exp frv=%b srv=%b rdata=%h",
                     cyc, fetch_rvalid, stack_rvalid, rdata, efv, esv, ed);
         end
      end
   end

   task automatic push_rd(input bit stk, input logic [15:0] addr);
      exp_t e;
      e.due  = cyc + 1;
      e.stk  = stk;
      e.data = ref_mem[addr];
      sb.push_back(e);
   endtask

   task automatic idle;
      @(posedge clk); #1;
      fetch_req = 1'b0; stack_req = 1'b0; stack_we = 1'b0; stack_lock = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      fetch_req = 1'b1; fetch_addr = 16'h1234;
      stack_req = 1'b1; stack_we = 1'b1; stack_addr = 16'h0040;
      stack_wdata = 16'h1111; stack_lock = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({fetch_gnt, stack_gnt, ram_wren, fg2, sg2, wren2} !== 6'b0) begin
         errors++;
         $display("FAIL reset_grants got fg=%b sg=%b wren=%b fg2=%b sg2=%b wren2=%b exp all 0",
                  fetch_gnt, stack_gnt, ram_wren, fg2, sg2, wren2);
      end
      checks++;
      if (ram_address !== 16'h1234) begin
         errors++;
         $display("FAIL reset_address got %h exp 1234", ram_address);
      end
      @(posedge clk); #1;
      rst = 1'b0; fetch_req = 1'b0; stack_req = 1'b0; stack_we = 1'b0; stack_lock = 1'b0;
      sb.delete();
      chk_en = 1'b1;
      @(negedge clk);
`ifdef RAM_ARB_STATS_EN
      exp_stall = 0;
      checks++;
      if (stall1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_stall_cnt got %h exp 0000", stall1);
      end
`endif
   endtask

   task automatic test_fetch_seq;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         fetch_req = 1'b1; fetch_addr = 16'(i);
         @(negedge clk);
         checks++;
         if (fetch_gnt !== 1'b1 || stack_gnt !== 1'b0 || ram_address !== 16'(i) || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL fetch_seq_grant got fg=%b sg=%b addr=%h wren=%b exp fg=1 sg=0 addr=%h wren=0",
                     fetch_gnt, stack_gnt, ram_address, ram_wren, 16'(i));
         end
         push_rd(1'b0, 16'(i));
      end
      @(posedge clk); #1;
      fetch_req = 1'b0; fetch_addr = 16'h0777;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b0 || ram_address !== 16'h0777 || ram_data !== 16'h0) begin
         errors++;
         $display("FAIL idle_mux got fg=%b addr=%h data=%h exp fg=0 addr=0777 data=0000",
                  fetch_gnt, ram_address, ram_data);
      end
   endtask

   task automatic test_contention;
      @(posedge clk); #1;
      fetch_req = 1'b1; fetch_addr = 16'h0010;
      stack_req = 1'b1; stack_we = 1'b0; stack_addr = 16'h00FF;
      @(negedge clk);
      checks++;
      if (stack_gnt !== 1'b1 || fetch_gnt !== 1'b0 || ram_address !== 16'h00FF) begin
         errors++;
         $display("FAIL contention got sg=%b fg=%b addr=%h exp sg=1 fg=0 addr=00ff",
                  stack_gnt, fetch_gnt, ram_address);
      end
      push_rd(1'b1, 16'h00FF);
`ifdef RAM_ARB_STATS_EN
      exp_stall++;
`endif
      @(posedge clk); #1;
      stack_req = 1'b0;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b1 || stack_gnt !== 1'b0 || ram_address !== 16'h0010) begin
         errors++;
         $display("FAIL contention_fetch got fg=%b sg=%b addr=%h exp fg=1 sg=0 addr=0010",
                  fetch_gnt, stack_gnt, ram_address);
      end
      push_rd(1'b0, 16'h0010);
      idle();
   endtask

   task automatic test_write_read;
      @(posedge clk); #1;
      stack_req = 1'b1; stack_we = 1'b1; stack_addr = 16'h0040; stack_wdata = 16'hBEEF;
      @(negedge clk);
      checks++;
      if (stack_gnt !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 16'h0040 || ram_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL stack_write got sg=%b wren=%b addr=%h data=%h exp sg=1 wren=1 addr=0040 data=beef",
                  stack_gnt, ram_wren, ram_address, ram_data);
      end
      ref_mem[16'h0040] = 16'hBEEF;
      @(posedge clk); #1;
      stack_we = 1'b0; stack_wdata = 16'h0000;
      @(negedge clk);
      checks++;
      if (stack_gnt !== 1'b1 || ram_wren !== 1'b0 || ram_address !== 16'h0040) begin
         errors++;
         $display("FAIL stack_read got sg=%b wren=%b addr=%h exp sg=1 wren=0 addr=0040",
                  stack_gnt, ram_wren, ram_address);
      end
      push_rd(1'b1, 16'h0040);
      idle();
   endtask

   task automatic test_starvation;
      bit ef;
      m_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         fetch_req = 1'b1; fetch_addr = 16'h0100;
         stack_req = 1'b1; stack_we = 1'b0; stack_addr = 16'h0200 + 16'(i); stack_lock = 1'b0;
         @(negedge clk);
         ef = (m_cnt == 4);
         checks++;
         if (fetch_gnt !== ef || stack_gnt !== !ef || ram_address !== (ef ? 16'h0100 : stack_addr)) begin
            errors++;
            $display("FAIL starve_cycle%0d got fg=%b sg=%b addr=%h exp fg=%b sg=%b",
                     i, fetch_gnt, stack_gnt, ram_address, ef, !ef);
         end
         push_rd(!ef, ef ? 16'h0100 : stack_addr);
         m_cnt = ef ? 0 : (m_cnt == 4 ? 4 : m_cnt + 1);
`ifdef RAM_ARB_STATS_EN
         if (!ef) exp_stall++;
`endif
      end
      idle();
   endtask

   task automatic test_lock;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         fetch_req = 1'b1; fetch_addr = 16'h0300;
         stack_req = 1'b1; stack_we = 1'b0; stack_addr = 16'h0400 + 16'(i); stack_lock = 1'b1;
         @(negedge clk);
         checks++;
         if (fetch_gnt !== 1'b0 || stack_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_cycle%0d got fg=%b sg=%b exp fg=0 sg=1", i, fetch_gnt, stack_gnt);
         end
         push_rd(1'b1, stack_addr);
`ifdef RAM_ARB_STATS_EN
         exp_stall++;
`endif
      end
      // Lock released with both still requesting: fetch has waited MAX_WAIT.
      @(posedge clk); #1;
      stack_lock = 1'b0;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b1 || stack_gnt !== 1'b0 || ram_address !== 16'h0300) begin
         errors++;
         $display("FAIL unlock_fetch got fg=%b sg=%b addr=%h exp fg=1 sg=0 addr=0300",
                  fetch_gnt, stack_gnt, ram_address);
      end
      push_rd(1'b0, 16'h0300);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b0 || stack_gnt !== 1'b1) begin
         errors++;
         $display("FAIL after_unlock got fg=%b sg=%b exp fg=0 sg=1", fetch_gnt, stack_gnt);
      end
      push_rd(1'b1, stack_addr);
`ifdef RAM_ARB_STATS_EN
      exp_stall++;
`endif
      // Lock without a stack request does not block fetch.
      @(posedge clk); #1;
      stack_req = 1'b0; stack_lock = 1'b1; fetch_addr = 16'h0301;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b1 || stack_gnt !== 1'b0) begin
         errors++;
         $display("FAIL lock_no_req got fg=%b sg=%b exp fg=1 sg=0", fetch_gnt, stack_gnt);
      end
      push_rd(1'b0, 16'h0301);
      idle();
      idle();
`ifdef RAM_ARB_STATS_EN
      checks++;
      if (stall1 !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL stall_cnt got %h exp %h", stall1, 16'(exp_stall));
      end
`endif
   endtask

   task automatic test_reset_inflight;
      @(posedge clk); #1;
      fetch_req = 1'b1; fetch_addr = 16'h0005;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b1 || fg2 !== 1'b1) begin
         errors++;
         $display("FAIL inflight_issue got fg=%b fg2=%b exp 1 1", fetch_gnt, fg2);
      end
      @(posedge clk); #1;
      rst = 1'b1; fetch_req = 1'b0;
      sb.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({frv2, srv2, fg2, sg2, wren2} !== 5'b0 || rdata2 !== 16'h0) begin
            errors++;
            $display("FAIL inflight_discard%0d got frv2=%b srv2=%b fg2=%b sg2=%b wren2=%b rdata2=%h exp all 0",
                     i, frv2, srv2, fg2, sg2, wren2, rdata2);
         end
         @(posedge clk); #1;
      end
`ifdef RAM_ARB_STATS_EN
      checks++;
      if (stall2 !== 16'h0 || stall1 !== 16'h0) begin
         errors++;
         $display("FAIL inflight_stall_cnt got %h/%h exp 0000", stall1, stall2);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      fetch_req = 1'b0; fetch_addr = '0;
      stack_req = 1'b0; stack_we = 1'b0; stack_addr = '0; stack_wdata = '0; stack_lock = 1'b0;
      test_reset();
      test_fetch_seq();
      test_contention();
      test_write_read();
      test_starvation();
      test_lock();
      test_reset_inflight();
      repeat (3) idle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
